// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer: LSB-first frames with optional even parity.
// Macro SIPO_PARITY_EN adds a trailing parity bit per frame and drives parity_err.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   si         serial data bit (LSB first)
//   si_valid   si carries a bit this cycle
//   sof        start of frame, qualified by si_valid
//   q          assembled parallel word
//   q_valid    q holds an unconsumed word
//   q_ready    consumer accepts q
//   busy       frame in progress
//   overrun    sticky: a completed frame was dropped
//   parity_err parity result of the word in q (0 when parity disabled)
module sipo_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             si_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
`endif

  state_t state, nxt;

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic [CW-1:0]    cnt;
  logic             start;
  logic             take;
  logic             last;
  logic             done;
  logic [WIDTH-1:0] word;
  logic             wpar;

  assign start = si_valid & sof;
  assign take  = si_valid & ~sof;
  assign last  = (cnt == CW'(WIDTH - 1));

  // Shift register holds zeros above the current bit position,
  // so OR-ing the new bit in at index cnt places bit k at q[k].
  assign sr_nxt = sr | (WIDTH'(si) << cnt);

`ifdef SIPO_PARITY_EN
  assign done = (state == PARITY) && take;
  assign word = sr;
  assign wpar = (^sr) ^ si;
`else
  assign done = (state == SHIFT) && take && last;
  assign word = sr_nxt;
  assign wpar = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start) nxt = SHIFT;
      end
      SHIFT: begin
        if (start) begin
          nxt = SHIFT;
        end else if (take && last) begin
`ifdef SIPO_PARITY_EN
          nxt = PARITY;
`else
          nxt = IDLE;
`endif
        end
      end
`ifdef SIPO_PARITY_EN
      PARITY: begin
        if (start)     nxt = SHIFT;
        else if (take) nxt = IDLE;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
  end

  // Shift register and bit counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (start) begin
      sr  <= WIDTH'(si);
      cnt <= CW'(1);
    end else if (take && state != IDLE) begin
      if (done) begin
        sr  <= '0;
        cnt <= '0;
      end else if (state == SHIFT) begin
        sr  <= sr_nxt;
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef SIPO_PARITY_EN
  logic perr;
  assign parity_err = perr;
`else
  assign parity_err = 1'b0;
`endif

  // Output register: a completed word is dropped only while the
  // previous one is still held and not being consumed this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q       <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
`ifdef SIPO_PARITY_EN
      perr    <= 1'b0;
`endif
    end else if (done) begin
      if (!q_valid || q_ready) begin
        q       <= word;
        q_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
        perr    <= wpar;
`endif
      end else begin
        overrun <= 1'b1;
      end
    end else if (q_valid && q_ready) begin
      q_valid <= 1'b0;
    end
  end

`ifndef SIPO_PARITY_EN
  logic unused_wpar;
  assign unused_wpar = wpar;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Testbench for sipo_deserializer (WIDTH=4): directed frames with a
// scoreboard queue of expected words checked by a negedge monitor.
module tb_sipo_deserializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         si = 1'b0;
  logic         si_valid = 1'b0;
  logic         sof = 1'b0;
  logic         q_ready = 1'b0;
  logic [W-1:0] q;
  logic         q_valid;
  logic         busy;
  logic         overrun;
  logic         parity_err;

  int npass = 0;
  int ntot  = 0;

  typedef struct packed {
    logic [W-1:0] w;
    logic         pe;
  } exp_t;

  exp_t sb[$];
  exp_t e_m;
  logic pv = 1'b0;
  logic pr = 1'b0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .si(si),
    .si_valid(si_valid),
    .sof(sof),
    .q(q),
    .q_valid(q_valid),
    .q_ready(q_ready),
    .busy(busy),
    .overrun(overrun),
    .parity_err(parity_err)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // A new word is presented when q_valid is high and either it was
  // low last cycle or the previous word was accepted on the edge.
  always @(negedge clk) begin
    if (q_valid && (!pv || pr)) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", 32'(q_valid), 32'd0);
      end else begin
        e_m = sb.pop_front();
        chk("mon_q", 32'(q), 32'(e_m.w));
        chk("mon_parity_err", 32'(parity_err), 32'(e_m.pe));
      end
    end
    pv = q_valid;
    pr = q_ready;
  end

  task automatic push(input logic [W-1:0] w, input logic pe);
    exp_t e;
    e.w  = w;
    e.pe = pe;
    sb.push_back(e);
  endtask

  task automatic send(input logic b, input logic s);
    si       = b;
    si_valid = 1'b1;
    sof      = s;
    @(posedge clk);
    #1;
    si_valid = 1'b0;
    sof      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [W-1:0] w, input logic pflip);
    for (int i = 0; i < W; i++) send(w[i], i == 0);
`ifdef SIPO_PARITY_EN
    send((^w) ^ pflip, 1'b0);
`else
    if (pflip) $display("note: parity flip ignored without parity");
`endif
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b0;
    #1;
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_q_valid", 32'(q_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(1);

    // Basic frame 1,1,0,1 -> 1011
    q_ready = 1'b1;
    push(4'b1011, 1'b0);
    send(1'b1, 1'b1);
    chk("busy_bit1", 32'(busy), 32'd1);
    send(1'b1, 1'b0);
    chk("busy_bit2", 32'(busy), 32'd1);
    send(1'b0, 1'b0);
    chk("busy_bit3", 32'(busy), 32'd1);
    send(1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
    chk("busy_data_done", 32'(busy), 32'd1);
    send(1'b1, 1'b0);
`endif
    chk("busy_after_frame", 32'(busy), 32'd0);
    chk("q_valid_after_frame", 32'(q_valid), 32'd1);
    idle(1);
    chk("q_valid_consumed", 32'(q_valid), 32'd0);

    // Abort: 1,0 then sof 0,0,1,1 -> only 1100; gaps hold state
    push(4'b1100, 1'b0);
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    idle(2);
    chk("busy_hold_gap", 32'(busy), 32'd1);
    frame(4'b1100, 1'b0);
    idle(2);

    // Overrun: 0110 held, 1111 dropped
    q_ready = 1'b0;
    push(4'b0110, 1'b0);
    frame(4'b0110, 1'b0);
    chk("held_q_valid", 32'(q_valid), 32'd1);
    frame(4'b1111, 1'b0);
    chk("ovr_q_kept", 32'(q), 32'(4'b0110));
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_q_valid", 32'(q_valid), 32'd1);
    idle(3);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    q_ready = 1'b1;
    idle(1);
    chk("ovr_drained", 32'(q_valid), 32'd0);
    chk("ovr_sticky2", 32'(overrun), 32'd1);

    // Reset mid-frame
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_q", 32'(q), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    chk("mid_rst_q_valid", 32'(q_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    chk("no_sof_busy", 32'(busy), 32'd0);
    chk("no_sof_q_valid", 32'(q_valid), 32'd0);
    idle(2);

    // Back-to-back 0001 then 1000, ready only on second completion
    q_ready = 1'b0;
    push(4'b0001, 1'b0);
    push(4'b1000, 1'b0);
    frame(4'b0001, 1'b0);
    send(1'b0, 1'b1);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
    send(1'b1, 1'b0);
    q_ready = 1'b1;
    send(1'b1, 1'b0);
`else
    q_ready = 1'b1;
    send(1'b1, 1'b0);
`endif
    chk("b2b_q", 32'(q), 32'(4'b1000));
    chk("b2b_q_valid", 32'(q_valid), 32'd1);
    chk("b2b_overrun", 32'(overrun), 32'd0);
    idle(2);

`ifdef SIPO_PARITY_EN
    // Parity good then bad
    push(4'b1011, 1'b0);
    frame(4'b1011, 1'b0);
    push(4'b1011, 1'b1);
    frame(4'b1011, 1'b1);
    idle(2);
`endif

    idle(3);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 Parameter WIDTH, default 4, data bits per frame (2..32).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 si  input  1  serial data bit, LSB first.
REQ-005 si_valid  input  1  si carries a bit this cycle.
REQ-006 sof  input  1  start of frame, qualified by si_valid; marks the bit as data bit 0.
REQ-007 q  output  WIDTH  assembled parallel word.
REQ-008 q_valid  output  1  q holds an unconsumed word.
REQ-009 q_ready  input  1  consumer accepts q when q_valid=1.
REQ-010 busy  output  1  frame in progress (state != IDLE).
REQ-011 overrun  output  1  sticky: a completed frame was dropped.
REQ-012 parity_err  output  1  parity result of the word currently in q.

Function
REQ-013 The block SHALL use a state machine with states IDLE, SHIFT and, when parity is enabled, PARITY; one shift register (WIDTH bits); a bit counter; and a separate output register q.
REQ-014 IDLE: si_valid&sof SHALL load si as bit 0, set count=1 and go to SHIFT (WIDTH>1); si_valid without sof SHALL be ignored.
REQ-015 SHIFT: each si_valid SHALL shift si in toward the MSB (bit k lands in q[k]) and increment count; cycles with si_valid=0 SHALL hold all state.
REQ-016 si_valid&sof in SHIFT or PARITY SHALL abort the partial frame and restart it with count=1; the discarded bits SHALL never reach q.
REQ-017 A frame completes on the edge sampling its last bit: data bit WIDTH-1, or the parity bit when parity is enabled; the state SHALL then return to IDLE.
REQ-018 On completion with q_valid=0, or with q_valid=1 and q_ready=1, q SHALL load the word and q_valid SHALL be 1 after that edge (zero extra latency).
REQ-019 On completion with q_valid=1 and q_ready=0, the new word SHALL be dropped; q, q_valid and parity_err SHALL remain unchanged; overrun SHALL become 1.
REQ-020 q_valid&q_ready with no completion on that edge SHALL clear q_valid; q SHALL keep its last value.
REQ-021 overrun SHALL clear only on reset.
REQ-022 busy SHALL be 1 in SHIFT and PARITY, 0 in IDLE.
REQ-023 Deserialization SHALL sustain one bit per clock with back-to-back frames; sof on the cycle after completion SHALL start a new frame without loss.

Reset
REQ-024 rst=0 SHALL immediately and asynchronously force: state IDLE, count 0, shift register 0, q 0, q_valid 0, busy 0, overrun 0, parity_err 0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; the first accepted bit after release requires sof.

Configuration
REQ-026 Macro SIPO_PARITY_EN defined: each frame SHALL carry one even-parity bit after data bit WIDTH-1 (state PARITY); parity_err SHALL load XOR(data bits, parity bit) with each delivered word.
REQ-027 Macro SIPO_PARITY_EN undefined: no PARITY state, frames are WIDTH bits, parity_err SHALL be constant 0; the port list SHALL be unchanged.

Verification (WIDTH=4)
REQ-028 Bits 1,1,0,1 (sof on the first), q_ready=1 -> q=4'b1011, q_valid=1 for one cycle after the 4th bit; busy=1 for bits 2-4 only.
REQ-029 Frame 4'b0110 held with q_ready=0, then frame 4'b1111 completes -> q stays 4'b0110, overrun=1 until reset.
REQ-030 Bits 1,0 then sof with bits 0,0,1,1 -> single word q=4'b1100; no word from the aborted frame.
REQ-031 rst pulsed low after 2 bits of a frame -> all outputs 0 asynchronously; 2 further bits without sof are ignored, busy stays 0.
REQ-032 Two back-to-back frames, 4'b0001 then 4'b1000, q_ready=1 on the completion edge of the second -> q goes 4'b0001 then 4'b1000, q_valid stays 1, overrun=0.
REQ-033 SIPO_PARITY_EN defined: data 4'b1011 with parity 1 -> parity_err=0; same data with parity 0 -> parity_err=1; in both cases q=4'b1011 and q_valid=1.
